// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : Byte-stream program loader; writes big-endian 16-bit words
//               into instruction memory from LOAD_BASE and releases the CPU.
//               Optional trailing XOR checksum: PROG_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int N         = 16,
    parameter int M         = 1024,
    parameter int LOAD_BASE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    output logic         mem_we,
    output logic         cpu_run,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LEN_LO  = 3'd1;
    localparam logic [2:0] S_WORD_HI = 3'd2;
    localparam logic [2:0] S_WORD_LO = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK     = 3'd6;
`endif

    // Largest word count that keeps LOAD_BASE+k inside the memory
    localparam logic [N-1:0] c_max_len   = N'(M - LOAD_BASE);
    localparam logic [N-1:0] c_load_base = N'(LOAD_BASE);
    localparam logic [N-1:0] c_one       = N'(1);

    logic [2:0]   r_state;
    logic         r_rx_ready;
    logic [7:0]   r_len_hi;
    logic [7:0]   r_hi;
    logic [N-1:0] r_len;
    logic [N-1:0] r_k;
    logic [N-1:0] r_mem_addr;
    logic [N-1:0] r_mem_wdata;
    logic         r_mem_we;
    logic         r_cpu_run;
    logic         r_busy;
    logic         r_done;
    logic         r_err;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]   r_csum;
`endif

    logic         w_accept;
    logic [N-1:0] w_len;
    logic [N-1:0] w_k_next;

    assign w_accept = rx_valid && r_rx_ready;
    assign w_len    = N'({r_len_hi, rx_data});
    assign w_k_next = r_k + c_one;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rx_ready  <= 1'b0;
            r_len_hi    <= 8'h00;
            r_hi        <= 8'h00;
            r_len       <= '0;
            r_k         <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_cpu_run   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            r_csum      <= 8'h00;
`endif
        end else begin
            // Status flags follow the state one cycle later, so done/cpu_run
            // appear the cycle after the final write pulse.
            r_mem_we   <= 1'b0;
            r_busy     <= !(r_state inside {S_IDLE, S_DONE, S_ERR});
            r_done     <= (r_state == S_DONE);
            r_cpu_run  <= (r_state == S_DONE);
            r_err      <= (r_state == S_ERR);
            r_rx_ready <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_len_hi <= rx_data;
                        r_state  <= S_LEN_LO;
                    end
                end

                S_LEN_LO: begin
                    if (w_accept) begin
                        r_len <= w_len;
                        r_k   <= '0;
                        if (w_len == '0) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_state    <= S_CHK;
`else
                            r_state    <= S_DONE;
                            r_rx_ready <= 1'b0;
`endif
                        end else if (w_len > c_max_len) begin
                            r_state    <= S_ERR;
                            r_rx_ready <= 1'b0;
                        end else begin
                            r_state <= S_WORD_HI;
                        end
                    end
                end

                S_WORD_HI: begin
                    if (w_accept) begin
                        r_hi    <= rx_data;
                        r_state <= S_WORD_LO;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_csum  <= r_csum ^ rx_data;
`endif
                    end
                end

                S_WORD_LO: begin
                    if (w_accept) begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= c_load_base + r_k;
                        r_mem_wdata <= N'({r_hi, rx_data});
                        r_k         <= w_k_next;
`ifdef PROG_LOADER_CHECKSUM_EN
                        r_csum      <= r_csum ^ rx_data;
`endif
                        if (w_k_next == r_len) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                            r_state    <= S_CHK;
`else
                            r_state    <= S_DONE;
                            r_rx_ready <= 1'b0;
`endif
                        end else begin
                            r_state <= S_WORD_HI;
                        end
                    end
                end

`ifdef PROG_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_accept) begin
                        r_state    <= (rx_data == r_csum) ? S_DONE : S_ERR;
                        r_rx_ready <= 1'b0;
                    end
                end
`endif

                S_DONE, S_ERR: begin
                    r_rx_ready <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rx_ready  = r_rx_ready;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign cpu_run   = r_cpu_run;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Directed self-checking bench for prog_loader; honours
//               PROG_LOADER_CHECKSUM_EN when the design is built with it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        cpu_run;
    logic        busy;
    logic        done;
    logic        err;

    always #5 clk = ~clk;

    prog_loader #(
        .N         (16),
        .M         (1024),
        .LOAD_BASE (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .cpu_run   (cpu_run),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int c_done_lat = 2;
`else
    localparam int c_done_lat = 1;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write/done recorder, sampled mid-cycle
    int          wr_cnt = 0;
    logic [15:0] wr_addr [32];
    logic [15:0] wr_data [32];
    int          wr_cyc  [32];
    int          done_cyc = -1;
    logic        r_done_q = 1'b0;

    always @(negedge clk) begin
        if (mem_we) begin
            if (wr_cnt < 32) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
                wr_cyc[wr_cnt]  = cyc;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (done && !r_done_q) done_cyc = cyc;
        r_done_q = done;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic acc;
        acc      = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20 && !acc; i++) begin
            acc = rx_ready;
            @(posedge clk);
            #1;
        end
        check("byte_accepted", acc, 1);
    endtask

    task automatic send_gap(input logic [7:0] b);
        send_byte(b);
        rx_valid = 1'b0;
        rx_data  = 8'hEE;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_end();
        for (int i = 0; i < 20 && !(done || err); i++) begin
            @(posedge clk);
            #1;
        end
        check("finish_timeout", done | err, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base;

        // Reset values
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        check("rst_rx_ready", rx_ready, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        check("rst_mem_wdata", mem_wdata, 16'h0000);
        check("rst_cpu_run", cpu_run, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_rx_ready", rx_ready, 1);

        // Back-to-back two-word frame
        base = wr_cnt;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h81); send_byte(8'h23);
        send_byte(8'hA0); send_byte(8'h05);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h07);
`endif
        rx_valid = 1'b0;
        wait_end();
        check("b2b_wr_count", wr_cnt - base, 2);
        check("b2b_addr0", wr_addr[base], 16'h0001);
        check("b2b_data0", wr_data[base], 16'h8123);
        check("b2b_addr1", wr_addr[base+1], 16'h0002);
        check("b2b_data1", wr_data[base+1], 16'hA005);
        check("b2b_done_lat", done_cyc - wr_cyc[base+1], c_done_lat);
        check("b2b_done", done, 1);
        check("b2b_cpu_run", cpu_run, 1);
        check("b2b_err", err, 0);
        check("b2b_busy", busy, 0);
        check("b2b_rx_ready", rx_ready, 0);

        // Zero-length frame
        do_reset();
        base = wr_cnt;
        send_byte(8'h00); send_byte(8'h00);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h00);
`endif
        rx_valid = 1'b0;
        wait_end();
        check("zero_wr_count", wr_cnt - base, 0);
        check("zero_done", done, 1);
        check("zero_cpu_run", cpu_run, 1);
        check("zero_rx_ready", rx_ready, 0);

        // Largest legal length is accepted
        do_reset();
        send_byte(8'h03); send_byte(8'hFF);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("maxlen_err", err, 0);
        check("maxlen_busy", busy, 1);
        check("maxlen_rx_ready", rx_ready, 1);

        // One past the limit is rejected, further bytes refused
        do_reset();
        base = wr_cnt;
        send_byte(8'h04); send_byte(8'h00);
        rx_valid = 1'b0;
        wait_end();
        check("ovf_err", err, 1);
        check("ovf_cpu_run", cpu_run, 0);
        check("ovf_done", done, 0);
        check("ovf_busy", busy, 0);
        rx_valid = 1'b1;
        rx_data  = 8'h55;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("ovf_rx_ready", rx_ready, 0);
        check("ovf_wr_count", wr_cnt - base, 0);
        rx_valid = 1'b0;

        // Gapped stream
        do_reset();
        base = wr_cnt;
        send_gap(8'h00); send_gap(8'h02);
        send_gap(8'h81); send_gap(8'h23);
        send_gap(8'hA0); send_gap(8'h05);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_gap(8'h07);
`endif
        wait_end();
        check("gap_wr_count", wr_cnt - base, 2);
        check("gap_addr0", wr_addr[base], 16'h0001);
        check("gap_data0", wr_data[base], 16'h8123);
        check("gap_addr1", wr_addr[base+1], 16'h0002);
        check("gap_data1", wr_data[base+1], 16'hA005);
        check("gap_done", done, 1);

        // Reset mid-frame, then a fresh one-word frame
        do_reset();
        base = wr_cnt;
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h81); send_byte(8'h23); send_byte(8'hA0);
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        check("mid_wr_count", wr_cnt - base, 1);
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("mid_rst_addr", mem_addr, 16'h0000);
        check("mid_rst_wdata", mem_wdata, 16'h0000);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rx_ready", rx_ready, 0);
        check("mid_rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        base = wr_cnt;
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_byte(8'h26);
`endif
        rx_valid = 1'b0;
        wait_end();
        check("fresh_wr_count", wr_cnt - base, 1);
        check("fresh_addr", wr_addr[base], 16'h0001);
        check("fresh_data", wr_data[base], 16'h1234);
        check("fresh_done", done, 1);
        check("fresh_cpu_run", cpu_run, 1);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Bad checksum: the write still happens, CPU stays held
        do_reset();
        base = wr_cnt;
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h12); send_byte(8'h34);
        send_byte(8'hFF);
        rx_valid = 1'b0;
        wait_end();
        check("csum_wr_count", wr_cnt - base, 1);
        check("csum_addr", wr_addr[base], 16'h0001);
        check("csum_data", wr_data[base], 16'h1234);
        check("csum_err", err, 1);
        check("csum_cpu_run", cpu_run, 0);
        check("csum_done", done, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Writer side of the instruction memory: receives a byte-stream program image, assembles N-bit instruction words and writes them into instruction memory through its write port (address, data in, write enable).
- Holds the CPU stopped while loading; raises cpu_run once the image is complete and valid.
- Sits between the host byte link and the instruction memory, so programs can be loaded without re-elaborating memory contents.

Parameters:
- N, 16, instruction word width in bits; must be 16 (two bytes per word).
- M, 1024, instruction memory depth in words.
- LOAD_BASE, 1, first word address written; matches the CPU reset program counter of 1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data valid.
- rx_ready  out  1  loader can accept a byte.
- mem_addr  out  N  instruction memory write address.
- mem_wdata  out  N  instruction memory write data.
- mem_we  out  1  instruction memory write enable, one-cycle pulse per word.
- cpu_run  out  1  CPU may execute; low while loading or on error.
- busy  out  1  frame in progress (length byte accepted, not yet DONE/ERR).
- done  out  1  image loaded successfully.
- err  out  1  frame rejected.

Behaviour:
- Byte accepted on posedge when rx_valid && rx_ready. rx_valid with rx_ready low is ignored; the byte is not consumed.
- Frame format: LEN_HI, LEN_LO (L = word count, big-endian), then 2*L payload bytes, each word big-endian (high byte first).
- Reset (rst_n low at posedge): state IDLE, rx_ready=0 for that cycle then 1; mem_we=0, mem_addr=0, mem_wdata=0, cpu_run=0, busy=0, done=0, err=0; word counter and checksum cleared. Reset mid-frame aborts the frame; the partially written memory is not cleared.
- States:
  - IDLE: accept LEN_HI -> LEN_LO; busy=1.
  - LEN_LO: accept byte and form L.
    - L==0 -> DONE (or CHK if the optional feature is enabled).
    - L > M-LOAD_BASE -> ERR.
    - Otherwise -> WORD_HI, with k=0.
  - WORD_HI: accept byte, latch it as the high byte -> WORD_LO.
  - WORD_LO: accept byte. On the next posedge: mem_we=1, mem_addr=LOAD_BASE+k, mem_wdata={hi,lo}, and k increments.
    - k+1==L -> DONE (or CHK).
    - Otherwise -> WORD_HI.
  - DONE: rx_ready=0, busy=0, done=1, cpu_run=1. Terminal until reset.
  - ERR: rx_ready=0, busy=0, err=1, cpu_run=0. Terminal until reset; no further writes.
- rx_ready=1 in IDLE, LEN_LO, WORD_HI, WORD_LO and CHK, so back-to-back bytes are accepted every cycle. The write pulse from word k overlaps acceptance of the next high byte.
- Write latency: mem_we is asserted exactly 1 cycle after the WORD_LO byte is accepted and lasts 1 cycle. mem_addr/mem_wdata hold their last values when mem_we=0.
- cpu_run rises in the same cycle as done and never rises together with err.
- Address arithmetic is N-bit. The length check guarantees LOAD_BASE+k <= M-1, so no wrap-around occurs.
- Address 0 is never written (the CPU halts when the program counter is 0).

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Defined:
  - After the last payload byte (or after LEN_LO when L==0), state CHK expects one byte equal to the XOR of all payload bytes (0x00 when L==0).
  - Match -> DONE; mismatch -> ERR.
  - The running XOR updates on every accepted payload byte.
  - The last word's mem_we pulse still fires; err only withholds cpu_run.
- Undefined: no CHK state and no checksum byte; the frame ends with the last payload byte.

Test Plan:
- Reset then stream 00 02 81 23 A0 05 back-to-back:
  - mem_we pulses with (addr 1, data 0x8123), then (addr 2, data 0xA005).
  - done=1 and cpu_run=1 one cycle after the last write (with checksum enabled, append byte 0x07 first).
- Stream 00 00 (plus 00 with checksum enabled) -> no mem_we, done=1, cpu_run=1, rx_ready=0.
- Length 0x0400 with M=1024, LOAD_BASE=1 -> err=1 after LEN_LO, no mem_we, cpu_run=0; further rx_valid bytes are not accepted.
- rx_valid toggled 1-0-1 with gaps of 3 idle cycles mid-word -> same writes as the back-to-back case; no extra or duplicate mem_we.
- rst_n asserted after 3 payload bytes of a 2-word frame -> all outputs return to reset values; a fresh frame 00 01 12 34 then writes 0x1234 at addr 1 and sets done.
- With checksum enabled, stream 00 01 12 34 then FF (expected 0x26) -> one write at addr 1, then err=1, cpu_run=0, done=0.
